// File: rtl/nco_pkg.sv
// Shared widths, types and ROM generator for the sine NCO.
package nco_pkg;

  localparam int PHASE_W  = 32;
  localparam int LUT_AW   = 8;
  localparam int AMP_LOG2 = 20;
  localparam int OUT_W    = 32;

  localparam logic [PHASE_W-1:0] INC_DEFAULT = 32'd429496730;

  localparam real PI = 3.141592653589793;

  typedef logic [PHASE_W-1:0]        phase_t;
  typedef logic signed [OUT_W-1:0]   sample_t;
  typedef logic [1:0]                quad_t;

  // Quarter-wave entry k: sine sampled at the centre of bin k, scaled to
  // 2^ampLog2 and rounded. The half-bin offset keeps every entry non-zero
  // and makes the mirrored read (~idx) land exactly on the reflected angle.
  function automatic int romEntry(input int k, input int aw, input int ampLog2);
    real angle;
    real scale;
    angle = PI / 2.0 * (real'(k) + 0.5) / real'(1 << aw);
    scale = real'(1 << ampLog2);
    return $rtoi($sin(angle) * scale + 0.5);
  endfunction

endpackage

// File: rtl/nco_quarter_rom.sv
// Quarter-wave sine ROM, contents generated at elaboration, registered read.
module nco_quarter_rom
  import nco_pkg::*;
#(
  parameter int AW = LUT_AW,
  parameter int DW = AMP_LOG2 + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] addr_i,
  output logic [DW-1:0] data_o
);

  logic [DW-1:0] romTable [2**AW];
  logic [DW-1:0] data_q;

  for (genvar k = 0; k < 2**AW; k++) begin : gRom
    assign romTable[k] = DW'(romEntry(k, AW, DW - 1));
  end

  // Synchronous read; cleared on reset so no stale magnitude survives it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= romTable[addr_i];
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/nco_sine_gen.sv
// Phase-accumulator sine source: accumulator, quadrant fold, ROM, sign stage.
module nco_sine_gen
  import nco_pkg::*;
#(
  parameter int                 PHASE_W     = nco_pkg::PHASE_W,
  parameter int                 LUT_AW      = nco_pkg::LUT_AW,
  parameter int                 AMP_LOG2    = nco_pkg::AMP_LOG2,
  parameter int                 OUT_W       = nco_pkg::OUT_W,
  parameter logic [PHASE_W-1:0] INC_DEFAULT = nco_pkg::INC_DEFAULT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_en,
  input  logic                    io_inc_load,
  input  logic [PHASE_W-1:0]      io_phase_inc,
  output logic signed [OUT_W-1:0] io_out_value,
  output logic                    io_out_valid
);

  localparam int ROM_DW = AMP_LOG2 + 1;

  logic [PHASE_W-1:0]      acc_q;
  logic [PHASE_W-1:0]      inc_q;
  logic [LUT_AW-1:0]       idx_d;
  logic [LUT_AW-1:0]       idx_q;
  quad_t                   quad_d;
  quad_t                   quad0_q;
  quad_t                   quad1_q;
  logic                    v0_q;
  logic                    v1_q;
  logic                    valid_q;
  logic [ROM_DW-1:0]       romData;
  logic signed [OUT_W-1:0] value_d;
  logic signed [OUT_W-1:0] value_q;

  // Fold the current phase into a quadrant and a quarter-wave ROM index.
  always_comb begin
    quad_d = acc_q[PHASE_W-1 -: 2];
    idx_d  = acc_q[PHASE_W-3 -: LUT_AW];
    if (quad_d[0]) begin
      idx_d = ~acc_q[PHASE_W-3 -: LUT_AW];
    end
  end

  // Phase accumulator and increment register; a same-cycle load only takes
  // effect on the following step because the add uses the registered value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      inc_q <= INC_DEFAULT;
    end else begin
      if (io_en) begin
        acc_q <= acc_q + inc_q;
      end
      if (io_inc_load) begin
        inc_q <= io_phase_inc;
      end
    end
  end

  // Stage 0: capture the folded address of the pre-update phase.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v0_q    <= 1'b0;
      idx_q   <= '0;
      quad0_q <= '0;
    end else begin
      v0_q <= io_en;
      if (io_en) begin
        idx_q   <= idx_d;
        quad0_q <= quad_d;
      end
    end
  end

  nco_quarter_rom #(
    .AW (LUT_AW),
    .DW (ROM_DW)
  ) uRom (
    .clock  (clock),
    .reset  (reset),
    .addr_i (idx_q),
    .data_o (romData)
  );

  // Stage 1: carry the quadrant alongside the ROM read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v1_q    <= 1'b0;
      quad1_q <= '0;
    end else begin
      v1_q <= v0_q;
      if (v0_q) begin
        quad1_q <= quad0_q;
      end
    end
  end

  // Lower half of the wave is the negated magnitude.
  always_comb begin
    value_d = $signed({{(OUT_W - ROM_DW){1'b0}}, romData});
    if (quad1_q[1]) begin
      value_d = -$signed({{(OUT_W - ROM_DW){1'b0}}, romData});
    end
  end

  // Stage 2: output register holds its value between valid samples.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      value_q <= '0;
    end else begin
      valid_q <= v1_q;
      if (v1_q) begin
        value_q <= value_d;
      end
    end
  end

  assign io_out_value = value_q;
  assign io_out_valid = valid_q;

endmodule

// File: tb/tb_nco_sine_gen.sv
// Self-checking bench for nco_sine_gen against an ideal sampled-sine model.
module tb_nco_sine_gen;

  localparam int unsigned DEF_INC = 32'd429496730;

  logic                clock = 1'b0;
  logic                reset;
  logic                io_en;
  logic                io_inc_load;
  logic [31:0]         io_phase_inc;
  logic signed [31:0]  io_out_value;
  logic                io_out_valid;

  int          testsRun = 0;
  int          testsFailed = 0;
  int          cycleNo = 0;
  int unsigned mAcc;
  int unsigned mInc;
  longint      lastVal;
  bit          expV [int];
  int          expS [int];
  int          gotQ [$];

  nco_sine_gen dut (
    .clock        (clock),
    .reset        (reset),
    .io_en        (io_en),
    .io_inc_load  (io_inc_load),
    .io_phase_inc (io_phase_inc),
    .io_out_value (io_out_value),
    .io_out_valid (io_out_valid)
  );

  always #5 clock = ~clock;

  // Ideal sine of the phase quantised to 1024 points per turn, sampled at bin centres.
  function automatic int refSample(input int unsigned phase);
    real angle;
    real v;
    angle = 2.0 * 3.141592653589793 * (real'(phase >> 22) + 0.5) / 1024.0;
    v = $sin(angle) * 1048576.0;
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(0.5 - v);
  endfunction

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    testsRun++;
    if (observed != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cycleNo);
    end
  endtask

  task automatic checkCycle();
    bit ev;
    ev = expV.exists(cycleNo);
    checkOutput("valid", longint'(io_out_valid), longint'(ev));
    if (ev) begin
      checkOutput("value", io_out_value, expS[cycleNo]);
      lastVal = expS[cycleNo];
      expV.delete(cycleNo);
      expS.delete(cycleNo);
    end else begin
      checkOutput("hold", io_out_value, lastVal);
    end
    if (io_out_valid) gotQ.push_back(io_out_value);
  endtask

  task automatic modelReset();
    expV.delete();
    expS.delete();
    mAcc = 0;
    mInc = DEF_INC;
    lastVal = 0;
  endtask

  // One clock: drive inputs, advance the model, check at the following negedge.
  task automatic applyStimulus(input bit en, input bit load, input logic [31:0] inc);
    io_en = en;
    io_inc_load = load;
    io_phase_inc = inc;
    if (en) begin
      expV[cycleNo + 3] = 1'b1;
      expS[cycleNo + 3] = refSample(mAcc);
      mAcc += mInc;
    end
    if (load) mInc = inc;
    @(posedge clock);
    cycleNo++;
    @(negedge clock);
    checkCycle();
  endtask

  task automatic doReset();
    io_en = 1'b0;
    io_inc_load = 1'b0;
    reset = 1'b1;
    modelReset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic drain();
    repeat (4) applyStimulus(1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    int maxAbs;
    int seq [4];
    reset = 1'b1;
    io_en = 1'b0;
    io_inc_load = 1'b0;
    io_phase_inc = '0;
    modelReset();
    repeat (2) @(negedge clock);
    checkOutput("rst_valid", longint'(io_out_valid), 0);
    checkOutput("rst_value", io_out_value, 0);
    reset = 1'b0;

    // Quarter-turn increment: four-sample repeating pattern.
    gotQ.delete();
    applyStimulus(1'b0, 1'b1, 32'h4000_0000);
    repeat (12) applyStimulus(1'b1, 1'b0, 32'h0);
    drain();
    seq = '{3217, 1048571, -3217, -1048571};
    checkOutput("quarter_count", gotQ.size(), 12);
    if (gotQ.size() >= 8) begin
      for (int i = 0; i < 8; i++) checkOutput("quarter_seq", gotQ[i], seq[i % 4]);
    end

    // Default increment: ten-sample period, bounded peak.
    doReset();
    gotQ.delete();
    repeat (20) applyStimulus(1'b1, 1'b0, 32'h0);
    drain();
    checkOutput("default_count", gotQ.size(), 20);
    if (gotQ.size() == 20) begin
      maxAbs = 0;
      for (int i = 0; i < 10; i++) begin
        checkOutput("period", gotQ[i + 10], refSample(32'(i) * DEF_INC));
      end
      for (int i = 0; i < 20; i++) begin
        if (gotQ[i] > maxAbs) maxAbs = gotQ[i];
        if (-gotQ[i] > maxAbs) maxAbs = -gotQ[i];
      end
      checkOutput("peak_ok", longint'(maxAbs <= 1048576), 1);
    end

    // Gapped enables: valid follows the enable pattern, value holds between.
    gotQ.delete();
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    drain();
    checkOutput("gap_count", gotQ.size(), 3);

    // Load coincident with enable: old increment used once, then half-turn steps.
    gotQ.delete();
    applyStimulus(1'b0, 1'b1, 32'h4000_0000);
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h8000_0000);
    repeat (6) applyStimulus(1'b1, 1'b0, 32'h0);
    drain();
    checkOutput("load_count", gotQ.size(), 8);
    if (gotQ.size() == 8) begin
      for (int k = 2; k < 7; k++) checkOutput("antiphase_sum", gotQ[k] + gotQ[k + 1], 0);
    end

    // Asynchronous reset between edges with samples in flight.
    repeat (4) applyStimulus(1'b1, 1'b0, 32'h0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput("async_valid", longint'(io_out_valid), 0);
    checkOutput("async_value", io_out_value, 0);
    @(negedge clock);
    io_en = 1'b0;
    io_inc_load = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    gotQ.delete();
    repeat (4) applyStimulus(1'b1, 1'b0, 32'h0);
    drain();
    checkOutput("post_rst_count", gotQ.size(), 4);
    if (gotQ.size() >= 1) checkOutput("post_rst_first", gotQ[0], 3217);

    // Near-full-turn increment: wraps every step, fourth-quadrant samples.
    doReset();
    gotQ.delete();
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF);
    repeat (12) applyStimulus(1'b1, 1'b0, 32'h0);
    drain();
    if (gotQ.size() >= 6) begin
      checkOutput("wrap_first", gotQ[0], 3217);
      checkOutput("wrap_q3", gotQ[1], -3217);
      checkOutput("wrap_q3_later", gotQ[5], -3217);
    end else begin
      checkOutput("wrap_count", gotQ.size(), 12);
    end

    // Randomized enables, loads and increments.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] inc;
      inc = $urandom;
      if ($urandom_range(0, 7) == 0) inc = 32'h0;
      else if ($urandom_range(0, 7) == 0) inc = 32'h8000_0000;
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, inc);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
